// File: rtl/fp_div_pkg.sv
// Shared definitions for the FP divider back end: special-result codes,
// IEEE-754 single constants and the round/pack stage state encoding.
package fp_div_pkg;

    localparam int unsigned QW_DEF    = 27;
    localparam int unsigned EXP_W_DEF = 10;
    localparam int unsigned FRAC_W    = 23;
    localparam int unsigned EXP_BIAS  = 127;

    localparam logic [1:0] SPC_NORMAL = 2'b00;
    localparam logic [1:0] SPC_ZERO   = 2'b01;
    localparam logic [1:0] SPC_INF    = 2'b10;
    localparam logic [1:0] SPC_NAN    = 2'b11;

    localparam logic [31:0] QNAN         = 32'h7FC0_0000;
    localparam logic [7:0]  EXP_ALL_ONES = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_NORM,
        ST_ROUND,
        ST_PACK,
        ST_OUT
    } state_t;

endpackage

// File: rtl/fp_round_ne.sv
// Round-to-nearest-even on a 23-bit fraction given guard and sticky bits.
module fp_round_ne
    import fp_div_pkg::*;
(
    input  logic [FRAC_W-1:0] frac,
    input  logic              g,
    input  logic              s,
    output logic [FRAC_W-1:0] frac_rounded,
    output logic              carry,
    output logic              inexact
);

    logic          inc;
    logic [FRAC_W:0] sum;

    // Ties go to the even fraction: only an odd LSB breaks an exact half upward.
    assign inc          = g & (s | frac[0]);
    assign sum          = {1'b0, frac} + (FRAC_W + 1)'(inc);
    assign frac_rounded = sum[FRAC_W-1:0];
    assign carry        = sum[FRAC_W];
    assign inexact      = g | s;

endmodule

// File: rtl/fp_div_round_pack.sv
// FP divider back end: normalize the raw quotient, round nearest-even and
// pack an IEEE-754 single result, with valid/ready on both sides.
module fp_div_round_pack
    import fp_div_pkg::*;
#(
    parameter int unsigned QW    = QW_DEF,
    parameter int unsigned EXP_W = EXP_W_DEF
) (
    input  logic             int_clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [QW-1:0]    in_quot,
    input  logic             in_sticky,
    input  logic [1:0]       in_special,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_overflow,
    output logic             out_underflow,
    output logic             out_inexact
);

    localparam int unsigned EW1 = EXP_W + 1;
    localparam logic signed [EW1-1:0] E_OVF = EW1'(2 * EXP_BIAS + 1);
    localparam logic signed [EW1-1:0] E_MIN = '0;

    state_t state, state_n;
    logic   in_ready_n, out_valid_n;

    logic                    sign_q;
    logic signed [EXP_W-1:0] exp_q;
    logic [QW-1:0]           quot_q;
    logic                    sticky_q;
    logic [1:0]              spc_q;

    logic [FRAC_W-1:0]       frac_q;
    logic                    g_q, s_q, inexact_q;
    logic signed [EW1-1:0]   e_q;

    logic signed [EW1-1:0]   exp_ext;
    logic [FRAC_W-1:0]       frac_n;
    logic                    g_n, s_n;
    logic signed [EW1-1:0]   e_n;

    logic [FRAC_W-1:0]       frac_rnd;
    logic                    carry_rnd, inexact_rnd;

    logic [31:0]             result_n;
    logic                    ovf_n, unf_n, inx_n;

    // State and handshake flags
    always_ff @(posedge int_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            in_ready  <= in_ready_n;
            out_valid <= out_valid_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE:  if (in_valid) state_n = ST_NORM;
            ST_NORM:  state_n = ST_ROUND;
            ST_ROUND: state_n = ST_PACK;
            ST_PACK:  state_n = ST_OUT;
            ST_OUT:   if (out_ready) state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
        in_ready_n  = (state_n == ST_IDLE);
        out_valid_n = (state_n == ST_OUT);
    end

    // Normalize: a quotient below 1.0 has one more leading fraction bit to drop
    assign exp_ext = EW1'(exp_q);

    always_comb begin
        if (quot_q[QW-1]) begin
            frac_n = quot_q[QW-2:QW-24];
            g_n    = quot_q[QW-25];
            s_n    = (|quot_q[QW-26:0]) | sticky_q;
            e_n    = exp_ext;
        end else begin
            frac_n = quot_q[QW-3:QW-25];
            g_n    = quot_q[QW-26];
            s_n    = (|quot_q[QW-27:0]) | sticky_q;
            e_n    = exp_ext - EW1'(1);
        end
    end

    fp_round_ne u_round (
        .frac         (frac_q),
        .g            (g_q),
        .s            (s_q),
        .frac_rounded (frac_rnd),
        .carry        (carry_rnd),
        .inexact      (inexact_rnd)
    );

    // Pack with specials taking precedence over range saturation
    always_comb begin
        result_n = {sign_q, e_q[7:0], frac_q};
        ovf_n    = 1'b0;
        unf_n    = 1'b0;
        inx_n    = inexact_q;
        unique case (spc_q)
            SPC_NAN: begin
                result_n = QNAN;
                inx_n    = 1'b0;
            end
            SPC_INF: begin
                result_n = {sign_q, EXP_ALL_ONES, {FRAC_W{1'b0}}};
                inx_n    = 1'b0;
            end
            SPC_ZERO: begin
                result_n = {sign_q, 31'b0};
                inx_n    = 1'b0;
            end
            SPC_NORMAL: begin
                if (e_q >= E_OVF) begin
                    result_n = {sign_q, EXP_ALL_ONES, {FRAC_W{1'b0}}};
                    ovf_n    = 1'b1;
                end else if (e_q <= E_MIN) begin
                    result_n = {sign_q, 31'b0};
                    unf_n    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Pipeline datapath, each step enabled by its state
    always_ff @(posedge int_clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q        <= 1'b0;
            exp_q         <= '0;
            quot_q        <= '0;
            sticky_q      <= 1'b0;
            spc_q         <= SPC_NORMAL;
            frac_q        <= '0;
            g_q           <= 1'b0;
            s_q           <= 1'b0;
            e_q           <= '0;
            inexact_q     <= 1'b0;
            out_result    <= '0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
            out_inexact   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        sign_q   <= in_sign;
                        exp_q    <= in_exp;
                        quot_q   <= in_quot;
                        sticky_q <= in_sticky;
                        spc_q    <= in_special;
                    end
                end
                ST_NORM: begin
                    frac_q <= frac_n;
                    g_q    <= g_n;
                    s_q    <= s_n;
                    e_q    <= e_n;
                end
                ST_ROUND: begin
                    frac_q    <= frac_rnd;
                    e_q       <= e_q + EW1'(carry_rnd);
                    inexact_q <= inexact_rnd;
                end
                ST_PACK: begin
                    out_result    <= result_n;
                    out_overflow  <= ovf_n;
                    out_underflow <= unf_n;
                    out_inexact   <= inx_n;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_round_pack.sv
// Self-checking bench for fp_div_round_pack: directed cases plus random
// quotients compared against an arithmetic round-to-nearest-even model.
module tb_fp_div_round_pack;

    logic        int_clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [26:0] in_quot;
    logic        in_sticky;
    logic [1:0]  in_special;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        out_underflow;
    logic        out_inexact;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    always #5 int_clk = ~int_clk;

    fp_div_round_pack dut (
        .int_clk       (int_clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sign       (in_sign),
        .in_exp        (in_exp),
        .in_quot       (in_quot),
        .in_sticky     (in_sticky),
        .in_special    (in_special),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow),
        .out_inexact   (out_inexact)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Returns {overflow, underflow, inexact, result}: keep the top 24
    // significant bits of q, round the discarded tail against one half.
    function automatic logic [34:0] model(input bit sign, input int e_in,
                                          input logic [26:0] q, input bit sticky,
                                          input logic [1:0] spc);
        longint qq, sig, rem, half;
        int     blen, sh, e;
        bit     ix;
        if (spc == 2'b11) return {3'b000, 32'h7FC00000};
        if (spc == 2'b10) return {3'b000, sign, 8'hFF, 23'd0};
        if (spc == 2'b01) return {3'b000, sign, 31'd0};
        qq = longint'(q);
        blen = 0;
        while ((qq >> blen) != 0) blen++;
        sh   = blen - 24;
        e    = e_in - (27 - blen);
        sig  = qq >> sh;
        rem  = qq - (sig << sh);
        half = longint'(1) << (sh - 1);
        if (rem > half || (rem == half && (sticky || (sig % 2) == 1))) sig = sig + 1;
        if (sig == (longint'(1) << 24)) begin
            sig = sig >> 1;
            e   = e + 1;
        end
        ix = (rem != 0) || sticky;
        if (e >= 255) return {1'b1, 1'b0, ix, sign, 8'hFF, 23'd0};
        if (e <= 0)   return {1'b0, 1'b1, ix, sign, 31'd0};
        return {1'b0, 1'b0, ix, sign, 8'(e), 23'(sig)};
    endfunction

    task automatic run_one(input bit sign, input int e_in, input logic [26:0] q,
                           input bit sticky, input logic [1:0] spc, input int stall,
                           input string tag, output logic [31:0] res);
        logic [34:0] ev;
        logic [31:0] held;
        int n;
        ev = model(sign, e_in, q, sticky, spc);
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge int_clk);
            n++;
        end
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        out_ready  = (stall == 0);
        in_valid   = 1'b1;
        in_sign    = sign;
        in_exp     = 10'(e_in);
        in_quot    = q;
        in_sticky  = sticky;
        in_special = spc;
        @(posedge int_clk);
        #1 in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge int_clk);
            n++;
        end while (!out_valid && n < 20);
        check({tag, " latency"}, 32'(n), 32'd4);
        check({tag, " result"}, out_result, ev[31:0]);
        check({tag, " ovf"}, 32'(out_overflow), 32'(ev[34]));
        check({tag, " unf"}, 32'(out_underflow), 32'(ev[33]));
        check({tag, " inx"}, 32'(out_inexact), 32'(ev[32]));
        res  = out_result;
        held = out_result;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            in_quot  = 27'(q ^ 27'h155_5555);
            @(negedge int_clk);
            check({tag, " hold valid"}, 32'(out_valid), 32'd1);
            check({tag, " hold result"}, out_result, held);
            check({tag, " hold ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge int_clk);
        check({tag, " ready after"}, 32'(in_ready), 32'd1);
        check({tag, " valid after"}, 32'(out_valid), 32'd0);
        in_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        int          e_r;
        int          k;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_sign    = 1'b0;
        in_exp     = '0;
        in_quot    = '0;
        in_sticky  = 1'b0;
        in_special = 2'b00;
        out_ready  = 1'b1;
        #12;
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_result", out_result, 32'd0);
        check("rst flags", {29'd0, out_overflow, out_underflow, out_inexact}, 32'd0);
        @(negedge int_clk);
        rst_n = 1'b1;
        @(negedge int_clk);

        run_one(1'b0, 129, 27'h4000000, 1'b0, 2'b00, 0, "8/2", r);
        check("8/2 lit", r, 32'h40800000);
        run_one(1'b1, 128, 27'h5000000, 1'b0, 2'b00, 0, "13.75/-5.5", r);
        check("13.75/-5.5 lit", r, 32'hC0200000);
        run_one(1'b0, 126, 27'h2AAAAAA, 1'b1, 2'b00, 0, "1/3", r);
        check("1/3 lit", r, 32'h3EAAAAAB);
        run_one(1'b0, 127, 27'h7FFFFFF, 1'b0, 2'b00, 0, "carry", r);
        check("carry lit", r, 32'h40000000);
        run_one(1'b1, 300, 27'h4000000, 1'b0, 2'b00, 0, "ovf", r);
        check("ovf lit", r, 32'hFF800000);
        run_one(1'b0, -5, 27'h4000000, 1'b0, 2'b00, 0, "unf", r);
        check("unf lit", r, 32'h00000000);
        run_one(1'b0, 254, 27'h7FFFFFF, 1'b0, 2'b00, 0, "carry to ovf", r);
        run_one(1'b0, 1, 27'h2000001, 1'b0, 2'b00, 0, "norm to unf", r);
        run_one(1'b0, 130, 27'h4000004, 1'b0, 2'b00, 0, "tie even", r);
        run_one(1'b0, 130, 27'h400000C, 1'b0, 2'b00, 0, "tie odd", r);
        run_one(1'b1, 100, 27'h6543210, 1'b1, 2'b00, 5, "backpressure", r);
        run_one(1'b0, 5, 27'h1234567, 1'b1, 2'b11, 0, "nan", r);
        check("nan lit", r, 32'h7FC00000);
        run_one(1'b1, 500, 27'h4000000, 1'b1, 2'b10, 0, "inf", r);
        check("inf lit", r, 32'hFF800000);
        run_one(1'b1, 130, 27'h4000000, 1'b0, 2'b01, 0, "zero", r);

        // Reset while the result is in ROUND
        @(negedge int_clk);
        in_valid   = 1'b1;
        in_sign    = 1'b0;
        in_exp     = 10'd129;
        in_quot    = 27'h4000000;
        in_sticky  = 1'b0;
        in_special = 2'b00;
        @(posedge int_clk);
        #1 in_valid = 1'b0;
        @(posedge int_clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst in_ready", 32'(in_ready), 32'd1);
        check("midrst out_result", out_result, 32'd0);
        @(negedge int_clk);
        rst_n = 1'b1;
        @(negedge int_clk);
        run_one(1'b0, 129, 27'h4000000, 1'b0, 2'b00, 0, "post rst 8/2", r);
        check("post rst lit", r, 32'h40800000);

        for (int i = 0; i < 40; i++) begin
            k   = int'($urandom_range(7, 0));
            e_r = int'($urandom_range(330, 0)) - 15;
            run_one(1'($urandom_range(1, 0)), e_r,
                    27'($urandom_range(27'h7FFFFFF, 27'h2000001)),
                    1'($urandom_range(1, 0)),
                    (k < 5) ? 2'b00 : 2'(k - 4),
                    (i % 8 == 3) ? 2 : 0,
                    $sformatf("rnd%0d", i), r);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
